// File: rtl/vector_line_sequencer.sv
// Vector line sequencer: walks a display-list ROM (MOVE / LINE / END),
// interpolates LINE entries with Bresenham steps at a fixed point rate and
// drives registered X/Y DAC codes plus a beam blanking signal.
//
// state  | meaning
// -------+--------------------------------------------------------------
// FETCH  | present addr, latch and decode entry when en=1, else hold
// SETTLE | blanked dwell after a MOVE, then advance to next entry
// DRAW   | one Bresenham point every STEP_CYCLES until target reached
module vector_line_sequencer #(
  parameter int OUT_WIDTH     = 8,
  parameter int COORD_WIDTH   = 8,
  parameter int ADDRESSWIDTH  = 8,
  parameter int DATAWIDTH     = 18,
  parameter int STEP_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DATAWIDTH-1:0]    data_in,
  output logic [ADDRESSWIDTH-1:0] addr,
  output logic [OUT_WIDTH-1:0]    x_ch,
  output logic [OUT_WIDTH-1:0]    y_ch,
  output logic                    blank,
  output logic                    frame_drawn
);

  localparam int EW    = COORD_WIDTH + 2;
  localparam int SHIFT = OUT_WIDTH - COORD_WIDTH;
  localparam int TMAX  = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [1:0] {S_FETCH, S_SETTLE, S_DRAW} state_t;

  state_t                   state, state_nxt;
  logic [ADDRESSWIDTH-1:0]  addr_nxt;
  logic [COORD_WIDTH-1:0]   cx, cy, cx_nxt, cy_nxt;
  logic [COORD_WIDTH-1:0]   cnt, cnt_nxt;
  logic [TW-1:0]            tmr, tmr_nxt;
  logic signed [EW-1:0]     err, err_nxt, dx, dx_nxt, dy, dy_nxt;
  logic                     sx, sx_nxt, sy, sy_nxt;
  logic                     blank_nxt, frame_nxt;

  // Entry fields and LINE setup values derived from the ROM word.
  logic [1:0]             op;
  logic [COORD_WIDTH-1:0] tx, ty, adx, ady;
  logic signed [EW-1:0]   dx_new, dy_new;

  assign op     = data_in[1:0];
  assign tx     = data_in[COORD_WIDTH+1:2];
  assign ty     = data_in[2*COORD_WIDTH+1:COORD_WIDTH+2];
  assign adx    = (tx >= cx) ? tx - cx : cx - tx;
  assign ady    = (ty >= cy) ? ty - cy : cy - ty;
  assign dx_new = $signed({2'b00, adx});
  assign dy_new = -$signed({2'b00, ady});

  // One Bresenham step from the current error term.
  logic signed [EW-1:0]   e2, err_step;
  logic                   step_x, step_y;
  logic [COORD_WIDTH-1:0] cx_step, cy_step;

  assign e2       = err + err;
  assign step_x   = (e2 >= dy);
  assign step_y   = (e2 <= dx);
  assign err_step = err + (step_x ? dy : EW'(0)) + (step_y ? dx : EW'(0));
  assign cx_step  = step_x ? (sx ? cx + COORD_WIDTH'(1) : cx - COORD_WIDTH'(1)) : cx;
  assign cy_step  = step_y ? (sy ? cy + COORD_WIDTH'(1) : cy - COORD_WIDTH'(1)) : cy;

  assign x_ch = OUT_WIDTH'(cx) << SHIFT;
  assign y_ch = OUT_WIDTH'(cy) << SHIFT;

  // Next-state and datapath decode; leaving the last address acts as an END.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    cx_nxt    = cx;
    cy_nxt    = cy;
    cnt_nxt   = cnt;
    tmr_nxt   = tmr;
    err_nxt   = err;
    dx_nxt    = dx;
    dy_nxt    = dy;
    sx_nxt    = sx;
    sy_nxt    = sy;
    blank_nxt = blank;
    frame_nxt = 1'b0;
    case (state)
      S_FETCH: begin
        if (en) begin
          case (op)
            2'b01: begin
              blank_nxt = 1'b0;
              dx_nxt    = dx_new;
              dy_nxt    = dy_new;
              err_nxt   = dx_new + dy_new;
              sx_nxt    = (tx >= cx);
              sy_nxt    = (ty >= cy);
              cnt_nxt   = (adx > ady) ? adx : ady;
              tmr_nxt   = TW'(STEP_CYCLES - 1);
              state_nxt = S_DRAW;
            end
            2'b11: begin
              frame_nxt = 1'b1;
              addr_nxt  = '0;
              blank_nxt = 1'b1;
            end
            default: begin
              cx_nxt    = tx;
              cy_nxt    = ty;
              blank_nxt = 1'b1;
              tmr_nxt   = TW'(SETTLE_CYCLES - 1);
              state_nxt = S_SETTLE;
            end
          endcase
        end
      end
      S_SETTLE: begin
        if (tmr == '0) begin
          addr_nxt  = addr + ADDRESSWIDTH'(1);
          frame_nxt = &addr;
          state_nxt = S_FETCH;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      S_DRAW: begin
        if (tmr == '0) begin
          tmr_nxt = TW'(STEP_CYCLES - 1);
          if (cnt != '0) begin
            cx_nxt  = cx_step;
            cy_nxt  = cy_step;
            err_nxt = err_step;
            cnt_nxt = cnt - COORD_WIDTH'(1);
          end
          if (cnt <= COORD_WIDTH'(1)) begin
            addr_nxt  = addr + ADDRESSWIDTH'(1);
            frame_nxt = &addr;
            state_nxt = S_FETCH;
          end
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // State register; reset drops any line in progress and blanks the beam.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      addr        <= '0;
      cx          <= '0;
      cy          <= '0;
      cnt         <= '0;
      tmr         <= '0;
      err         <= '0;
      dx          <= '0;
      dy          <= '0;
      sx          <= 1'b0;
      sy          <= 1'b0;
      blank       <= 1'b1;
      frame_drawn <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      cx          <= cx_nxt;
      cy          <= cy_nxt;
      cnt         <= cnt_nxt;
      tmr         <= tmr_nxt;
      err         <= err_nxt;
      dx          <= dx_nxt;
      dy          <= dy_nxt;
      sx          <= sx_nxt;
      sy          <= sy_nxt;
      blank       <= blank_nxt;
      frame_drawn <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_vector_line_sequencer.sv
// Directed bench: default-parameter instance for sequencing, lines, enable
// and reset; a 12-bit-DAC / 2-bit-address instance for scaling and wrap.
module tb_vector_line_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en0, en1;

  logic [17:0] rom0 [0:255];
  logic [17:0] d0;
  logic [7:0]  addr0, x0, y0;
  logic        blank0, fd0;
  assign d0 = rom0[addr0];

  logic [17:0] rom1 [0:3];
  logic [17:0] d1;
  logic [1:0]  addr1;
  logic [11:0] x1, y1;
  logic        blank1, fd1;
  assign d1 = rom1[addr1];

  vector_line_sequencer #(
    .OUT_WIDTH(8), .COORD_WIDTH(8), .ADDRESSWIDTH(8), .DATAWIDTH(18),
    .STEP_CYCLES(4), .SETTLE_CYCLES(16)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en0), .data_in(d0), .addr(addr0),
    .x_ch(x0), .y_ch(y0), .blank(blank0), .frame_drawn(fd0)
  );

  vector_line_sequencer #(
    .OUT_WIDTH(12), .COORD_WIDTH(8), .ADDRESSWIDTH(2), .DATAWIDTH(18),
    .STEP_CYCLES(1), .SETTLE_CYCLES(1)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en1), .data_in(d1), .addr(addr1),
    .x_ch(x1), .y_ch(y1), .blank(blank1), .frame_drawn(fd1)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [17:0] ent(input logic [1:0] op, input int x, input int y);
    return {y[7:0], x[7:0], op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom0;
    for (int i = 0; i < 256; i++) rom0[i] = ent(2'b11, 0, 0);
  endtask

  task automatic wait_addr0(input int a, input int limit);
    int k;
    k = 0;
    while (addr0 !== a[7:0] && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("wait_addr", 32'(addr0), a);
  endtask

  // Follow one LINE entry at address a from its FETCH edge to the edge that
  // advances addr; verify point count, spacing, step shape and endpoint.
  task automatic trace_line(input string tag, input int a, input int n,
                            input int tx, input int ty, input bit steep);
    int cyc, pts, bad, ddx, ddy, nexp;
    logic [7:0] px, py;
    bit done;
    cyc = 0; pts = 0; bad = 0; done = 1'b0;
    px = x0; py = y0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (blank0 !== 1'b0) bad++;
      if (x0 !== px || y0 !== py) begin
        pts++;
        ddx = int'(x0) - int'(px);
        ddy = int'(y0) - int'(py);
        if ((cyc - 1) % 4 != 0) bad++;
        if (ddx > 1 || ddx < -1 || ddy > 1 || ddy < -1) bad++;
        if (steep && ddy != 1 && ddy != -1) bad++;
        px = x0;
        py = y0;
      end
      if (addr0 !== a[7:0]) done = 1'b1;
    end
    nexp = 1 + ((n == 0) ? 1 : n) * 4;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_points"}, pts, n);
    chk({tag, "_x_end"}, 32'(x0), tx);
    chk({tag, "_y_end"}, 32'(y0), ty);
    chk({tag, "_shape"}, bad, 0);
    chk({tag, "_cycles"}, cyc, nexp);
  endtask

  initial begin
    int ki, ex, eb, ea, ef, bad;
    rst = 1'b0; en0 = 1'b1; en1 = 1'b0;
    for (int i = 0; i < 4; i++) rom1[i] = ent(2'b11, 0, 0);
    clear_rom0();
    rom0[0] = ent(2'b00, 10, 20);
    rom0[1] = ent(2'b01, 13, 20);
    rom0[2] = ent(2'b11, 0, 0);
    nclk(2);
    chk("reset_addr", 32'(addr0), 0);
    chk("reset_x", 32'(x0), 0);
    chk("reset_y", 32'(y0), 0);
    chk("reset_blank", 32'(blank0), 1);
    chk("reset_frame", 32'(fd0), 0);

    // Four 31-cycle frames: MOVE (17) + LINE of 3 points (13) + END (1).
    rst = 1'b1;
    for (int k = 1; k <= 124; k++) begin
      nclk(1);
      ki = ((k - 1) % 31) + 1;
      ex = (ki <= 21) ? 10 : (ki <= 25) ? 11 : (ki <= 29) ? 12 : 13;
      eb = (ki <= 17 || ki == 31) ? 1 : 0;
      ea = (ki <= 16) ? 0 : (ki <= 29) ? 1 : (ki == 30) ? 2 : 0;
      ef = (ki == 31) ? 1 : 0;
      chk($sformatf("frame_x k=%0d", k), 32'(x0), ex);
      chk($sformatf("frame_y k=%0d", k), 32'(y0), 20);
      chk($sformatf("frame_blank k=%0d", k), 32'(blank0), eb);
      chk($sformatf("frame_addr k=%0d", k), 32'(addr0), ea);
      chk($sformatf("frame_pulse k=%0d", k), 32'(fd0), ef);
    end

    // Steep lines out and back.
    rst = 1'b0;
    clear_rom0();
    rom0[0] = ent(2'b00, 0, 0);
    rom0[1] = ent(2'b01, 3, 7);
    rom0[2] = ent(2'b01, 0, 0);
    rom0[3] = ent(2'b11, 0, 0);
    nclk(1);
    rst = 1'b1;
    wait_addr0(1, 40);
    trace_line("steep_up", 1, 7, 3, 7, 1'b1);
    trace_line("steep_down", 2, 7, 0, 0, 1'b1);

    // Zero-length line, then enable dropped mid-line.
    rst = 1'b0;
    clear_rom0();
    rom0[0] = ent(2'b00, 5, 5);
    rom0[1] = ent(2'b01, 5, 5);
    rom0[2] = ent(2'b01, 8, 5);
    rom0[3] = ent(2'b00, 0, 0);
    rom0[4] = ent(2'b11, 0, 0);
    nclk(1);
    rst = 1'b1;
    wait_addr0(1, 40);
    chk("zero_len_start_x", 32'(x0), 5);
    trace_line("zero_len", 1, 0, 5, 5, 1'b0);
    nclk(6);
    chk("mid_draw_x", 32'(x0), 6);
    en0 = 1'b0;
    nclk(7);
    chk("en_low_line_done_addr", 32'(addr0), 3);
    chk("en_low_line_done_x", 32'(x0), 8);
    nclk(20);
    chk("en_low_hold_addr", 32'(addr0), 3);
    chk("en_low_hold_x", 32'(x0), 8);
    chk("en_low_hold_y", 32'(y0), 5);
    en0 = 1'b1;
    nclk(1);
    chk("en_resume_x", 32'(x0), 0);
    chk("en_resume_blank", 32'(blank0), 1);

    // Asynchronous reset in the middle of a line.
    wait_addr0(2, 100);
    nclk(6);
    chk("pre_reset_x", 32'(x0), 6);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_x", 32'(x0), 0);
    chk("async_reset_y", 32'(y0), 0);
    chk("async_reset_blank", 32'(blank0), 1);
    chk("async_reset_addr", 32'(addr0), 0);
    chk("async_reset_frame", 32'(fd0), 0);
    nclk(2);
    rst = 1'b1;
    nclk(1);
    chk("restart_x", 32'(x0), 5);
    chk("restart_addr", 32'(addr0), 0);
    chk("restart_blank", 32'(blank0), 1);

    // Wide DAC, full-range diagonal and address wrap without END.
    rom1[0] = ent(2'b00, 255, 1);
    rom1[1] = ent(2'b10, 0, 0);
    rom1[2] = ent(2'b01, 255, 255);
    rom1[3] = ent(2'b00, 7, 9);
    en1 = 1'b1;
    nclk(1);
    chk("scale_x", 32'(x1), 4080);
    chk("scale_y", 32'(y1), 16);
    chk("scale_blank", 32'(blank1), 1);
    nclk(3);
    chk("reserved_move_addr", 32'(addr1), 2);
    chk("reserved_move_x", 32'(x1), 0);
    nclk(1);
    chk("diag_blank", 32'(blank1), 0);
    bad = 0;
    for (int k = 1; k <= 255; k++) begin
      nclk(1);
      if (x1 !== 12'(k * 16) || y1 !== 12'(k * 16)) bad++;
    end
    chk("diag_path", bad, 0);
    chk("diag_end_addr", 32'(addr1), 3);
    chk("diag_end_x", 32'(x1), 4080);
    chk("diag_end_y", 32'(y1), 4080);
    nclk(1);
    chk("last_move_x", 32'(x1), 112);
    chk("last_move_y", 32'(y1), 144);
    chk("last_move_frame", 32'(fd1), 0);
    nclk(1);
    chk("wrap_addr", 32'(addr1), 0);
    chk("wrap_frame", 32'(fd1), 1);
    nclk(1);
    chk("wrap_frame_clear", 32'(fd1), 0);
    chk("wrap_refetch_x", 32'(x1), 4080);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
